// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default line timing, data width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned UART_CLK_FREQ  = 50_000_000;
  localparam int unsigned UART_BAUD      = 115200;
  localparam int unsigned UART_DATA_BITS = 8;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receive-side bundle: serial line in, parallel byte and status out.
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic                      rx_in;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      frame_err;
  logic                      busy;

  modport master (
    input  rx_in,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx_in,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a falling-edge detector.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Reset to idle-high so release never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_in};
      prev_q <= sync_q[1];
    end
  end

  assign rx_sync = sync_q[1];
  assign rx_fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver sampling at bit centres.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = UART_CLK_FREQ,
  parameter int unsigned BAUD     = UART_BAUD,
  parameter int unsigned BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.master rx
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam int DW = UART_DATA_BITS;

  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DW - 1);

  logic rx_sync;
  logic rx_fall;
  logic samp;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx.rx_in),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_sync};
    end
  end

  assign samp = maj3(hist_q[1], hist_q[0], rx_sync);
`else
  assign samp = rx_sync;
`endif

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] shift_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          err_q;
  logic          busy_q;

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_fall) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!samp) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (cnt_q == LAST) begin
            shift_q <= {samp, shift_q[DW-1:1]};
            idx_q   <= idx_q + IW'(1);
            if (idx_q == IMAX) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          // Leave mid stop bit so a back-to-back start edge is seen.
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (samp) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = err_q;
  assign rx.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at BAUD_DIV = 10.
// Glitch expectation follows UART_RX_MAJORITY_EN.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int DIV = 10;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GL_EXP = 8'h55;
`else
  localparam logic [7:0] GL_EXP = 8'hAA;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_byte_if rx_if ();

  uart_rx_byte #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt  = 0;
  int ecnt  = 0;
  int both  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.rx_valid) vcnt++;
      if (rx_if.frame_err) ecnt++;
      if (rx_if.rx_valid && rx_if.frame_err) both++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic v);
    @(posedge clk);
    #1 rx_if.rx_in = v;
  endtask

  // Drive the first ncyc cycles of a frame, one line value per clock.
  task automatic send(
    input logic [7:0] b,
    input logic       stop,
    input logic       gl,
    input int         ncyc
  );
    for (int k = 0; k < ncyc; k++) begin
      int   bi;
      int   j;
      logic v;
      bi = k / DIV;
      j  = k % DIV;
      if (bi == 0) v = 1'b0;
      else if (bi <= 8) v = b[bi-1];
      else v = stop;
      if (gl && bi >= 1 && bi <= 8 && j == DIV / 2) v = ~v;
      tick(v);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       gl;
    int         hold;
    int         gap;
    int         ev;
    int         ee;
    logic [7:0] ed;
  } vec_t;

  vec_t tv[7];

  initial begin
    int v0;
    int e0;

    tv[0] = '{8'hC5, 1'b1, 1'b0, 0, 0, 1, 0, 8'hC5};
    tv[1] = '{8'h6A, 1'b1, 1'b0, 0, 3, 1, 0, 8'h6A};
    tv[2] = '{8'h00, 1'b1, 1'b0, 0, 3, 1, 0, 8'h00};
    tv[3] = '{8'hFF, 1'b1, 1'b0, 0, 3, 1, 0, 8'hFF};
    tv[4] = '{8'hA5, 1'b1, 1'b0, 0, 3, 1, 0, 8'hA5};
    tv[5] = '{8'h3C, 1'b0, 1'b0, 30, 5, 0, 1, 8'hA5};
    tv[6] = '{8'h55, 1'b1, 1'b1, 0, 5, 1, 0, GL_EXP};

    rx_if.rx_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", rx_if.rx_data, 8'h00);
    chk("rst_valid", rx_if.rx_valid, 0);
    chk("rst_err", rx_if.frame_err, 0);
    chk("rst_busy", rx_if.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick(1'b1);

    // Short low pulse: rejected at the start-bit sample.
    v0 = vcnt;
    e0 = ecnt;
    repeat (3) tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    chk("glitch_busy_hi", rx_if.busy, 1);
    repeat (5) tick(1'b1);
    chk("glitch_busy_lo", rx_if.busy, 0);
    repeat (20) tick(1'b1);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_err", ecnt - e0, 0);

    for (int i = 0; i < 7; i++) begin
      v0 = vcnt;
      e0 = ecnt;
      send(tv[i].d, tv[i].stop, tv[i].gl, 10 * DIV);
      repeat (tv[i].hold) tick(tv[i].stop);
      repeat (tv[i].gap) tick(1'b1);
      chk($sformatf("v%0d_valid", i), vcnt - v0, tv[i].ev);
      chk($sformatf("v%0d_err", i), ecnt - e0, tv[i].ee);
      chk($sformatf("v%0d_data", i), rx_if.rx_data, tv[i].ed);
      if (tv[i].gap > 0)
        chk($sformatf("v%0d_busy", i), rx_if.busy, 0);
    end

    // Reset in the middle of data bit 4.
    v0 = vcnt;
    e0 = ecnt;
    send(8'h96, 1'b1, 1'b0, 5 * DIV + 5);
    chk("mid_busy_pre", rx_if.busy, 1);
    rst = 1'b1;
    rx_if.rx_in = 1'b1;
    @(negedge clk);
    chk("mid_data", rx_if.rx_data, 8'h00);
    chk("mid_valid", rx_if.rx_valid, 0);
    chk("mid_err", rx_if.frame_err, 0);
    chk("mid_busy", rx_if.busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) tick(1'b1);
    chk("mid_no_valid", vcnt - v0, 0);
    chk("mid_no_err", ecnt - e0, 0);
    send(8'h81, 1'b1, 1'b0, 10 * DIV);
    repeat (3) tick(1'b1);
    chk("post_valid", vcnt - v0, 1);
    chk("post_data", rx_if.rx_data, 8'h81);
    chk("post_busy", rx_if.busy, 0);

    chk("never_both", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Single-byte UART receiver: deserialises an 8N1 frame from an asynchronous serial line into a parallel byte with a one-cycle valid strobe. It sits directly downstream of `one_byte_uart_tx`, shares its bit timing (same clock/baud division), and is the receive half used in loopback tests and board-level links.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `BAUD_DIV`, default `CLK_FREQ/BAUD` (434): clock cycles per bit; must be ≥ 4.
- `clk`  in  1  system clock; one clock domain, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_in`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last correctly framed byte, LSB received first.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `busy`  out  1  high from start-edge detection until return to IDLE.

## Operation
- `rx_in` passes through a 2-FF synchroniser (reset value 1); a third register holds the previous synced value for edge detection.
- Bit counter: width `$clog2(BAUD_DIV)`, counts 0..`BAUD_DIV-1` then wraps to 0; cleared on entry to START.
- States: IDLE, START, DATA, STOP.
- IDLE: on synced falling edge (prev 1, now 0), go to START, clear counter, `busy`=1. A line held low does not retrigger.
- START: at count `BAUD_DIV/2-1` sample; 0 → DATA (counter cleared, bit index 0); 1 → IDLE (glitch rejected, no pulse).
- DATA: sample at count `BAUD_DIV-1`, shift into shift register MSB-first position so LSB ends at bit 0; after 8th sample → STOP.
- STOP: sample at count `BAUD_DIV-1`; 1 → load `rx_data`, pulse `rx_valid`; 0 → pulse `frame_err`, `rx_data` unchanged. Either way return to IDLE in the same cycle (mid stop bit) so the next start edge can be caught.
- `rx_valid` and `frame_err` are never high together.
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `busy`=0, state IDLE, counter 0, shift register 0.
- Reset mid-frame: all state cleared immediately; partial byte lost; no pulse emitted on release.

## Timing
- Synchroniser latency: 2 cycles from `rx_in` to synced value; edge detected the cycle after.
- Start sample at mid start bit; each data/stop sample `BAUD_DIV` cycles apart, i.e. at bit centres.
- `rx_valid`/`frame_err` registered: asserted 1 cycle after the stop-bit sample, for exactly 1 cycle; `busy` falls in that same cycle.
- Back-to-back frames (stop bit of 1 bit then immediate start) are received without loss.
- Tolerated baud mismatch: ±2% at the default `BAUD_DIV`.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each sample (start, data, stop) is the 2-of-3 majority of the synced line at counts sample−2, sample−1, sample; latency unchanged.
- Not defined: each sample is the single synced value at the sample count; majority logic absent.

## Structure
- Shared package `uart_pkg`: state encoding (IDLE/START/DATA/STOP), default `CLK_FREQ`/`BAUD`, `UART_DATA_BITS`=8; reused by `one_byte_uart_tx`.
- Sub-module `uart_rx_sync`: 2-FF synchroniser plus falling-edge detector, outputs `rx_sync` and `rx_fall`.

## Test plan
Bench uses `CLK_FREQ`=1000, `BAUD`=100 (`BAUD_DIV`=10).
- Frame 8'hC5 then 8'h6A back-to-back → two `rx_valid` pulses, `rx_data`=8'hC5 then 8'h6A, `frame_err` never high.
- Loopback from `one_byte_uart_tx` (same parameters) sending 8'h00, 8'hFF, 8'hA5 → `rx_data` matches each, one pulse per byte.
- `rx_in` low for 3 cycles then high → return to IDLE, no `rx_valid`/`frame_err`, `busy` drops after start sample.
- Frame 8'h3C with stop bit driven low → `frame_err` one-cycle pulse, `rx_data` keeps previous value; line held low afterwards produces no further activity.
- `rst` asserted during bit 4 of a frame → all outputs at reset values next edge; next valid frame 8'h81 received correctly.
- With `UART_RX_MAJORITY_EN`: 1-cycle glitch inverting the line at each data sample point of frame 8'h55 → `rx_data`=8'h55; without macro → mismatch expected.
